// File: rtl/iobuf_bank_turn_pkg.sv
// Shared types and elaboration helpers for the turnaround-controlled I/O bank.
// Holds the direction state encoding, the counter sizing and the parameter range checks.
package iobuf_pkg;

    typedef enum logic [1:0] {
        RX     = 2'd0,
        GAP_TX = 2'd1,
        TX     = 2'd2,
        GAP_RX = 2'd3
    } dir_state_e;

    // The down-counter must hold the larger of the two gap preloads.
    function automatic int cnt_width(input int turnaround, input int sync_stages);
        int span;
        span = turnaround + sync_stages + 1;
        return (span > 2) ? $clog2(span) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int sync_stages, input int turnaround);
        return (width >= 1) && (width <= 64) &&
               (sync_stages >= 1) && (sync_stages <= 3) &&
               (turnaround >= 0) && (turnaround <= 15);
    endfunction

endpackage

// File: rtl/iobuf_bank_turn_sync.sv
// Reset-clearable multi-stage synchroniser for the pad input path.
// Every stage is cleared by the synchronous reset so no stale pad data survives it.
module iobuf_sync
    import iobuf_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    // Next value of each stage: pad data enters stage 0 and shifts along.
    always_comb begin
        stage_d[0] = din;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stage_q[s] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/iobuf_bank_turn.sv
// Registered bidirectional pad bank with dead-cycle insertion on every bus turnaround.
// GTS releases the pads combinationally; the direction FSM follows on the next edge.
module iobuf_bank_turn
    import iobuf_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             GTS,
    input  logic [WIDTH-1:0] I,
    input  logic             T,
    inout  wire  [WIDTH-1:0] IO,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    output logic             DRIVING,
    output logic             BUSY
);

    localparam int            CW       = cnt_width(TURNAROUND, SYNC_STAGES);
    localparam logic [CW-1:0] TA_LOAD  = CW'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);
    localparam logic [CW-1:0] RX_LOAD  = CW'(SYNC_STAGES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!params_ok(WIDTH, SYNC_STAGES, TURNAROUND)) begin : g_param_check
        $error("iobuf_bank_turn: WIDTH, SYNC_STAGES or TURNAROUND out of range");
    end

    dir_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] out_q;

    // Direction FSM next state and gap counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RX: begin
                if (!T && !GTS) begin
                    if (TURNAROUND == 0) begin
                        state_d = TX;
                    end else begin
                        state_d = GAP_TX;
                        cnt_d   = TA_LOAD;
                    end
                end else begin
                    state_d = RX;
                end
            end
            GAP_TX: begin
                // Abort wins over expiry: the pads were never driven, so no gap is owed.
                if (T || GTS) begin
                    state_d = RX;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = TX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            TX: begin
                if (T || GTS) begin
                    state_d = GAP_RX;
                    cnt_d   = RX_LOAD;
                end else begin
                    state_d = TX;
                end
            end
            GAP_RX: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = RX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = GAP_RX;
                cnt_d   = RX_LOAD;
            end
        endcase
    end

    // Output decode from the next state so the outputs are registered alongside it.
    always_comb begin
        en_d      = 1'b0;
        busy_d    = 1'b1;
        o_valid_d = 1'b0;
        case (state_d)
            RX:      begin en_d = 1'b0; busy_d = 1'b0; o_valid_d = 1'b1; end
            GAP_TX:  begin en_d = 1'b0; busy_d = 1'b1; o_valid_d = 1'b1; end
            TX:      begin en_d = 1'b1; busy_d = 1'b0; o_valid_d = 1'b0; end
            GAP_RX:  begin en_d = 1'b0; busy_d = 1'b1; o_valid_d = 1'b0; end
            default: begin en_d = 1'b0; busy_d = 1'b1; o_valid_d = 1'b0; end
        endcase
    end

    // State, counter, drive data and registered status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= GAP_RX;
            cnt_q     <= RX_LOAD;
            en_q      <= 1'b0;
            busy_q    <= 1'b1;
            o_valid_q <= 1'b0;
            out_q     <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            o_valid_q <= o_valid_d;
            out_q     <= I;
        end
    end

    assign IO      = (en_q && !GTS) ? out_q : {WIDTH{1'bz}};
    assign DRIVING = en_q;
    assign BUSY    = busy_q;
    assign O_VALID = o_valid_q;

    iobuf_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  (IO),
        .dout (O)
    );

endmodule

// File: tb/tb_iobuf_bank_turn.sv
// Scoreboard bench for iobuf_bank_turn: directed stimulus queues expected status per cycle,
// a negedge monitor pops and compares; an external pad model drives the bus when the bank is off.
module tb_iobuf_bank_turn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, gts, t, t2, t3;
    logic [7:0] din;
    logic       ext_en, ext2_en;
    logic [7:0] ext_d;
    wire  [7:0] io_w;
    wire  [0:0] io2_w;
    wire  [7:0] io3_w;

    logic [7:0] o1, o3;
    logic [0:0] o2;
    logic       ov1, drv1, busy1, ov2, drv2, busy2, ov3, drv3, busy3;

    assign io_w  = ext_en  ? ext_d : 8'hzz;
    assign io2_w = ext2_en ? 1'b0  : 1'bz;

    iobuf_bank_turn #(.WIDTH(8), .SYNC_STAGES(2), .TURNAROUND(1)) dut (
        .CLK(clk), .RST(rst), .GTS(gts), .I(din), .T(t), .IO(io_w),
        .O(o1), .O_VALID(ov1), .DRIVING(drv1), .BUSY(busy1));

    iobuf_bank_turn #(.WIDTH(1), .SYNC_STAGES(2), .TURNAROUND(0)) dut2 (
        .CLK(clk), .RST(rst), .GTS(gts), .I(din[0]), .T(t2), .IO(io2_w),
        .O(o2), .O_VALID(ov2), .DRIVING(drv2), .BUSY(busy2));

    iobuf_bank_turn #(.WIDTH(8), .SYNC_STAGES(2), .TURNAROUND(3)) dut3 (
        .CLK(clk), .RST(rst), .GTS(gts), .I(din), .T(t3), .IO(io3_w),
        .O(o3), .O_VALID(ov3), .DRIVING(drv3), .BUSY(busy3));

    typedef struct {
        int         cyc;
        string      nm;
        int         sel;
        bit         ov;
        bit         drv;
        bit         busy;
        bit         cio;
        logic [7:0] io;
        bit         co;
        logic [7:0] o;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int cy, input string nm, input int sel, input bit ov, input bit drv,
                        input bit busy, input bit cio, input logic [7:0] io, input bit co,
                        input logic [7:0] o);
        exp_t e;
        e.cyc = cy; e.nm = nm; e.sel = sel; e.ov = ov; e.drv = drv; e.busy = busy;
        e.cio = cio; e.io = io; e.co = co; e.o = o;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: contention check every cycle, then pop and compare all entries due now.
    always @(negedge clk) begin
        exp_t e;
        bit   xbad;
        xbad = 1'b0;
        for (int b = 0; b < 8; b++) if (io_w[b] === 1'bx) xbad = 1'b1;
        if (io2_w[0] === 1'bx) xbad = 1'b1;
        checks++;
        if (xbad) begin
            errors++;
            $display("FAIL contention: io=%b io2=%b at cycle %0d, expected no X", io_w, io2_w, cyc);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: stale entry for cycle %0d, now %0d", e.nm, e.cyc, cyc);
            end else if (e.sel == 0) begin
                cmp({e.nm, ".ov"},   {7'd0, ov1},   {7'd0, e.ov});
                cmp({e.nm, ".drv"},  {7'd0, drv1},  {7'd0, e.drv});
                cmp({e.nm, ".busy"}, {7'd0, busy1}, {7'd0, e.busy});
                if (e.cio) cmp({e.nm, ".io"}, io_w, e.io);
                if (e.co)  cmp({e.nm, ".o"},  o1,   e.o);
            end else if (e.sel == 1) begin
                cmp({e.nm, ".drv"}, {7'd0, drv2}, {7'd0, e.drv});
            end else begin
                cmp({e.nm, ".ov"},   {7'd0, ov3},   {7'd0, e.ov});
                cmp({e.nm, ".drv"},  {7'd0, drv3},  {7'd0, e.drv});
                cmp({e.nm, ".busy"}, {7'd0, busy3}, {7'd0, e.busy});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; gts = 1'b0; t = 1'b1; t2 = 1'b1; t3 = 1'b1; din = 8'h00;
        ext_en = 1'b1; ext_d = 8'h00; ext2_en = 1'b1;

        // Reset: two edges into reset, outputs at their reset values.
        step(); step();
        push(2, "rst_hold", 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
        push(2, "rst_hold3", 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        rst = 1'b0;
        push(4, "rel_gap", 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        push(5, "rel_rx",  0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
        push(5, "rel_rx3", 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step(); step();

        // Turn-on with one dead cycle.
        t = 1'b0; din = 8'h3C;
        push(6, "on_gap",  0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        push(7, "on_tx",   0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        push(9, "on_echo", 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C);
        step();
        ext_en = 1'b0;
        step(); step(); step();
        din = 8'h77;
        push(10, "drv_lat", 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00);
        step();

        // Turn-off, external driver takes the bus after the release edge.
        t = 1'b1;
        push(11, "off_gap",  0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00);
        push(12, "off_gap2", 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00);
        push(13, "off_rx",   0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A);
        step();
        ext_en = 1'b1; ext_d = 8'h5A;
        step(); step();

        // GTS mid-TX: pads released in the same cycle, FSM leaves TX on the next edge.
        t = 1'b0; din = 8'hC3;
        push(14, "g_gap", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        push(15, "g_tx",  0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 8'h00);
        step();
        ext_en = 1'b0;
        step(); step();
        gts = 1'b1; ext_en = 1'b1; ext_d = 8'h00;
        push(16, "gts_z",   0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        push(17, "gts_gap", 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
        step();
        gts = 1'b0; t = 1'b1;
        push(19, "gts_rx", 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
        step(); step();

        // Reset asserted for two edges while driving 8'hA5.
        t = 1'b0; din = 8'hA5;
        push(21, "r_tx", 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
        step();
        ext_en = 1'b0;
        step();
        rst = 1'b1;
        push(22, "rst_tx",    0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
        push(23, "rst_tx2",   0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
        step();
        ext_en = 1'b1; ext_d = 8'h00; t = 1'b1;
        step();
        rst = 1'b0;
        push(24, "rst_gap", 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        push(25, "rst_rx",  0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
        step(); step();

        // TURNAROUND=3: abort out of GAP_TX, then a full turn-on.
        t3 = 1'b0;
        push(26, "a_gap", 2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        t3 = 1'b1;
        push(27, "a_rx",  2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        push(28, "a_rx2", 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step(); step();
        t3 = 1'b0;
        push(29, "b_gap1", 2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        push(30, "b_gap2", 2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        push(31, "b_gap3", 2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        push(32, "b_tx",   2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step(); step(); step(); step();
        t3 = 1'b1;

        // TURNAROUND=0, WIDTH=1: T toggles every 4 cycles, DRIVING is T inverted one edge later.
        for (int i = 0; i < 100; i++) begin
            logic tnew;
            tnew    = ((i / 4) % 2 == 0) ? 1'b0 : 1'b1;
            ext2_en = t2 && tnew;
            t2      = tnew;
            push(cyc + 1, "d2", 1, 1'b0, !tnew, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            step();
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
